// File: rtl/sram_mem_controller.sv
// Splits 32-bit word requests into two halfword accesses on a 16-bit asynchronous SRAM,
// holding each access for WAIT_CYCLES cycles and freezing the pipeline via ready.
module sram_mem_controller #(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(WAIT_CYCLES - 1);
    localparam logic [31:0]    BASE      = 32'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WCW-1:0]     wcnt_q, wcnt_d;
    logic               op_write_q, op_write_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [SRAM_AW-2:0] word_addr_q, word_addr_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0]        offset;
    logic               wcnt_last;
    logic               unused_offset_bits;

    // Byte offset from the SRAM window; higher bits drop out, so out-of-range addresses wrap.
    assign offset             = address - BASE;
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
    assign wcnt_last          = (wcnt_q == WCNT_LAST);
    assign rdata              = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            op_write_q  <= 1'b0;
            wdata_q     <= '0;
            word_addr_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            op_write_q  <= op_write_d;
            wdata_q     <= wdata_d;
            word_addr_q <= word_addr_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        op_write_d  = op_write_q;
        wdata_d     = wdata_q;
        word_addr_d = word_addr_q;
        rdata_d     = rdata_q;
        ready       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Combinational so the pipeline freezes in the very cycle the request appears.
                ready = ~(rd_en | wr_en);
                if (rd_en | wr_en) begin
                    op_write_d  = wr_en & ~rd_en;
                    wdata_d     = wdata;
                    word_addr_d = offset[SRAM_AW:2];
                    wcnt_d      = '0;
                    state_d     = S_LOW;
                end
            end
            S_LOW: begin
                if (wcnt_last) begin
                    if (!op_write_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                    wcnt_d  = '0;
                    state_d = S_HIGH;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_HIGH: begin
                if (wcnt_last) begin
                    if (!op_write_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                    wcnt_d  = '0;
                    state_d = S_DONE;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // SRAM pins depend only on registered state, never on the request inputs.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state_q)
            S_LOW: begin
                sram_addr = {word_addr_q, 1'b0};
                if (op_write_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                    sram_we_n   = 1'b0;
                end
            end
            S_HIGH: begin
                sram_addr = {word_addr_q, 1'b1};
                if (op_write_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                    sram_we_n   = 1'b0;
                end
            end
            default: begin
                sram_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: an SRAM array on the pins plus a word-level reference
// memory; directed scenarios followed by randomized read/write traffic.
module tb_sram_mem_controller;

    localparam int WAIT_CYCLES = 2;
    localparam int BASE_ADDR   = 1024;
    localparam int SRAM_AW     = 18;
    localparam logic [31:0] SPAN = 32'(1) << (SRAM_AW + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               rd_en, wr_en;
    logic [31:0]        address, wdata;
    logic [31:0]        rdata;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;
    logic               sram_we_n;

    bit [15:0]   sram [0:(1<<SRAM_AW)-1];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] last_rdata;
    int          checks = 0;
    int          errors = 0;

    sram_mem_controller #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .BASE_ADDR  (BASE_ADDR),
        .SRAM_AW    (SRAM_AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    assign sram_dq_in = sram[sram_addr];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int unsigned word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'(BASE_ADDR);
        return (off >> 2) & ((32'(1) << (SRAM_AW - 1)) - 1);
    endfunction

    function automatic logic [31:0] ref_read(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    // One full request: hold enables until ready, then drop them and look at the idle cycle.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data);
        int          cyc, low_cnt, we_cnt, half;
        bit          done, is_wr;
        int unsigned w;
        logic [31:0] exp_word;
        is_wr = wr && !rd;
        w     = word_of(addr);
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; address = addr; wdata = data;
        cyc = 0; low_cnt = 0; we_cnt = 0; done = 0;
        while (!done && cyc < 4 * WAIT_CYCLES + 8) begin
            @(negedge clk);
            if (ready) done = 1;
            else low_cnt++;
            if (!sram_we_n) we_cnt++;
            check("we_n_vs_oe", 32'(sram_we_n | sram_dq_oe), 32'(1));
            if (cyc >= 1 && cyc <= 2 * WAIT_CYCLES) begin
                half = (cyc > WAIT_CYCLES) ? 1 : 0;
                check("sram_addr", 32'(sram_addr), 32'(w * 2 + half));
                check("we_n", 32'(sram_we_n), 32'(!is_wr));
                check("dq_oe", 32'(sram_dq_oe), 32'(is_wr));
                if (is_wr) check("dq_out", 32'(sram_dq_out), half ? 32'(data[31:16]) : 32'(data[15:0]));
            end
            cyc++;
        end
        check("latency", 32'(cyc), 32'(2 * WAIT_CYCLES + 2));
        check("ready_low", 32'(low_cnt), 32'(2 * WAIT_CYCLES + 1));
        check("we_cycles", 32'(we_cnt), is_wr ? 32'(2 * WAIT_CYCLES) : 32'(0));
        if (is_wr) begin
            ref_mem[w] = data;
            check("rdata_kept", rdata, last_rdata);
        end else begin
            exp_word = ref_read(w);
            check("rdata", rdata, exp_word);
            last_rdata = exp_word;
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(ready), 32'(1));
        check("idle_we_n", 32'(sram_we_n), 32'(1));
        check("rdata_hold", rdata, last_rdata);
    endtask

    initial begin
        logic [31:0] a, d, old_word;
        int unsigned w;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; wdata = '0;
        last_rdata = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_we_n", 32'(sram_we_n), 32'(1));
        check("rst_dq_oe", 32'(sram_dq_oe), 32'(0));
        check("rst_sram_addr", 32'(sram_addr), 32'(0));
        check("rst_rdata", rdata, 32'h0);

        run_req(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
        check("sram_hw4", 32'(sram[4]), 32'h0000BEEF);
        check("sram_hw5", 32'(sram[5]), 32'h0000DEAD);
        run_req(1'b1, 1'b0, 32'd1032, 32'h0);

        // Both enables: must act as a read and leave memory untouched.
        run_req(1'b1, 1'b1, 32'd1032, 32'h0BADF00D);
        check("both_sram_lo", 32'(sram[4]), 32'(ref_read(2) & 32'hFFFF));
        check("both_sram_hi", 32'(sram[5]), 32'(ref_read(2) >> 16));

        // Abort a write in its first HIGH cycle. The upper half keeps its value in the
        // new data so the outcome does not hinge on how the SRAM treats the cut strobe.
        run_req(1'b0, 1'b1, 32'd1040, 32'h12345678);
        old_word = ref_read(word_of(32'd1040));
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1040; wdata = 32'h1234ABCD;
        repeat (WAIT_CYCLES + 1) @(posedge clk);
        #1 rst = 1'b1; wr_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'(1));
        check("abort_we_n", 32'(sram_we_n), 32'(1));
        check("abort_dq_oe", 32'(sram_dq_oe), 32'(0));
        check("abort_rdata", rdata, 32'h0);
        last_rdata = 32'h0;
        ref_mem[word_of(32'd1040)] = {old_word[31:16], 16'hABCD};
        run_req(1'b1, 1'b0, 32'd1040, 32'h0);

        // Back-to-back: read then write with one idle cycle between.
        run_req(1'b1, 1'b0, 32'd1024, 32'h0);
        run_req(1'b0, 1'b1, 32'd1028, 32'hCAFE0042);
        run_req(1'b1, 1'b0, 32'd1028, 32'h0);

        // Random traffic over a small window, including wrapped aliases and low address bits.
        for (int i = 0; i < 30; i++) begin
            a = 32'(BASE_ADDR) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                1: a = a + SPAN;
                2: a = a - SPAN;
                default: a = a;
            endcase
            d = $urandom;
            w = word_of(a);
            case ($urandom_range(0, 3))
                0, 1: run_req(1'b0, 1'b1, a, d);
                2: run_req(1'b1, 1'b0, a, d);
                default: run_req(1'b1, 1'b1, a, d);
            endcase
            check("rand_sram_lo", 32'(sram[w * 2]), ref_read(w) & 32'hFFFF);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Multi-cycle controller between the MEM stage and an external 16-bit-wide asynchronous SRAM.
- Turns a 32-bit word read/write request into two sequenced halfword SRAM accesses, each held for a programmable number of wait cycles.
- Drives `ready` low while busy. The top level uses `~ready` as the pipeline `freeze` and routes `rdata` into `mem_out` for WB.

Parameters:
- `WAIT_CYCLES`, default 2: cycles each halfword access is held on the SRAM bus. Legal range is ≥1.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `SRAM_AW`, default 18: SRAM halfword address width.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `rd_en` in 1: word read request. Held high by the requester until `ready`=1.
- `wr_en` in 1: word write request. Same hold rule as `rd_en`.
- `address` in 32: byte address, word-aligned. Bits [1:0] are ignored.
- `wdata` in 32: write data.
- `rdata` out 32: last completed read word.
- `ready` out 1: 1 = idle or completing. 0 = pipeline must freeze.
- `sram_addr` out `SRAM_AW`: SRAM halfword address.
- `sram_dq_out` out 16: SRAM write data.
- `sram_dq_oe` out 1: 1 = controller drives the DQ bus.
- `sram_dq_in` in 16: SRAM read data.
- `sram_we_n` out 1: SRAM write strobe, active-low.

Behaviour:
- **States:** IDLE, LOW, HIGH, DONE. Wait counter `wcnt` runs 0..`WAIT_CYCLES`-1.
- **Reset** (sync, wins over everything):
  - state=IDLE, `wcnt`=0, `rdata`=0, latched request cleared.
  - Outputs: `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.
  - Reset during LOW/HIGH aborts the access. A partially written word is left as-is; no recovery.
- **IDLE:**
  - `ready` is combinational: `ready` = ~(`rd_en` | `wr_en`). This gives freeze in the same cycle the request appears.
  - On a request: latch op, `wdata` and word address = (`address` - `BASE_ADDR`) >> 2, truncated to `SRAM_AW`-1 bits. Go to LOW with `wcnt`=0.
  - If both enables are high, it is a read. No write strobe occurs.
- **LOW:**
  - `sram_addr` = {word_addr, 1'b0}.
  - Write: `sram_dq_oe`=1, `sram_dq_out`=`wdata`[15:0], `sram_we_n`=0 for all `WAIT_CYCLES` cycles.
  - Read: `sram_dq_oe`=0, `sram_we_n`=1. Capture `sram_dq_in` into `rdata`[15:0] on the cycle where `wcnt`=`WAIT_CYCLES`-1.
  - On `wcnt`=`WAIT_CYCLES`-1: go to HIGH, `wcnt`=0. Otherwise increment `wcnt`.
  - `ready`=0.
- **HIGH:**
  - Same as LOW with `sram_addr` = {word_addr, 1'b1} and data bits [31:16].
  - Exits to DONE.
  - `ready`=0.
- **DONE:**
  - `ready`=1, `rdata` holds the full word. SRAM outputs are idle (`sram_we_n`=1, `sram_dq_oe`=0).
  - Request inputs are ignored; the pipeline advances on this edge.
  - Next state is always IDLE.
- **Timing:**
  - Request latency is 2·`WAIT_CYCLES`+2 cycles from the first request cycle to the DONE cycle inclusive.
  - `ready` is low for 2·`WAIT_CYCLES`+1 cycles.
- **Output rules:**
  - SRAM outputs are decoded from registered state, latched request and `wcnt`. They are glitch-free with respect to request inputs.
  - `sram_we_n` is high whenever `sram_dq_oe`=0.
  - `rdata` changes only on read captures or reset; writes never alter it.
- **Address range:** an address below `BASE_ADDR` or beyond SRAM size wraps modulo 2^(`SRAM_AW`-1) words. No error is flagged.
- **Back-to-back requests:** a request still high in the IDLE cycle after DONE is a new request and is executed again. The MEM stage must drop its enables once it is unfrozen.

Test Plan:
1. **Reset values:** assert `rst` 2 cycles, no request → `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `rdata`=0.
2. **Write** (`WAIT_CYCLES`=2): `wr_en`=1, `address`=1032, `wdata`=0xDEADBEEF.
   - Cycle 0: `ready`=0.
   - Cycles 1–2: `sram_addr`=4, `sram_dq_out`=0xBEEF, `we_n`=0.
   - Cycles 3–4: `sram_addr`=5, `sram_dq_out`=0xDEAD, `we_n`=0.
   - Cycle 5: `ready`=1, `we_n`=1.
3. **Read back** via SRAM model: `rd_en`=1, `address`=1032 → `ready` low 5 cycles, `we_n` never low, `rdata`=0xDEADBEEF in cycle 5 and held afterwards.
4. **Simultaneous enables:** `rd_en`=`wr_en`=1 → behaves exactly as a read, `sram_we_n` stays 1, SRAM model contents unchanged.
5. **Reset mid-write:** assert `rst` in the first HIGH cycle → next cycle state=IDLE, `we_n`=1, `dq_oe`=0, `ready`=1. A subsequent read completes normally in 6 cycles.
6. **Back-to-back:** read at 1024 then write at 1028 with enables dropped for one cycle between → two full sequences. `rdata` is unaffected by the write, and each access occurs exactly once.
